// File: rtl/decode_stage_if.sv
// Fetch-to-execute decode bus: fetch handshake, writeback port, flush and decoded bundle.
// The slave modport is the decode stage; the master modport is the surrounding pipeline.
interface decode_stage_if #(parameter int XLEN = 32);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instruction_i;
    logic [XLEN-1:0] pc_i;
    logic            wb_en_i;
    logic [4:0]      wb_addr_i;
    logic [XLEN-1:0] wb_data_i;
    logic            flush_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [3:0]      alu_ctrl_o;
    logic [XLEN-1:0] op1_o;
    logic [XLEN-1:0] op2_o;
    logic [XLEN-1:0] rs2_data_o;
    logic [4:0]      rd_o;
    logic            reg_wr_o;
    logic            mem_en_o;
    logic            mem_wr_o;
    logic            branch_en_o;
    logic [XLEN-1:0] pc_target_o;
    logic            illegal_o;

    modport slave (
        input  in_valid_i, instruction_i, pc_i, wb_en_i, wb_addr_i, wb_data_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_ctrl_o, op1_o, op2_o, rs2_data_o, rd_o, reg_wr_o,
               mem_en_o, mem_wr_o, branch_en_o, pc_target_o, illegal_o
    );
    modport master (
        output in_valid_i, instruction_i, pc_i, wb_en_i, wb_addr_i, wb_data_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_ctrl_o, op1_o, op2_o, rs2_data_o, rd_o, reg_wr_o,
               mem_en_o, mem_wr_o, branch_en_o, pc_target_o, illegal_o
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage: register file with writeback bypass, instruction decode,
// branch resolution and a single registered output bundle with valid/ready handshake.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic           clk_i,
    input logic           reset_ni,
    decode_stage_if.slave bus
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;
    localparam logic [6:0] OP_R = 7'h33, OP_IMM = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23,
                           OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                           OP_BR = 7'h63;

    function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [XLEN-1:0] rf_q [NREGS];

    logic [31:0] ins;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd_f, rs1_f, rs2_f;
    assign ins   = bus.instruction_i;
    assign opc   = ins[6:0];
    assign rd_f  = ins[11:7];
    assign f3    = ins[14:12];
    assign rs1_f = ins[19:15];
    assign rs2_f = ins[24:20];
    assign f7    = ins[31:25];

    // Immediates built at 32 bits as signed values, then sign-extended to XLEN by the cast.
    logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
    assign imm_i32 = {{20{ins[31]}}, ins[31:20]};
    assign imm_s32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u32 = {ins[31:12], 12'b0};
    assign imm_j32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
    assign imm_i = XLEN'(imm_i32);
    assign imm_s = XLEN'(imm_s32);
    assign imm_b = XLEN'(imm_b32);
    assign imm_u = XLEN'(imm_u32);
    assign imm_j = XLEN'(imm_j32);
    assign shamt = XLEN'(rs2_f);

    // Read port: x0 is hard zero, a same-cycle writeback is forwarded ahead of the array.
    function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] idx, input logic [XLEN-1:0] arr);
        if (idx == 5'd0 || 32'(idx) >= NREGS) return '0;
        if (bus.wb_en_i && bus.wb_addr_i == idx) return bus.wb_data_i;
        return arr;
    endfunction

    logic [XLEN-1:0] rs1_val, rs2_val;
    assign rs1_val = rd_reg(rs1_f, rf_q[rs1_f[AW-1:0]]);
    assign rs2_val = rd_reg(rs2_f, rf_q[rs2_f[AW-1:0]]);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (bus.wb_en_i && bus.wb_addr_i != 5'd0 && 32'(bus.wb_addr_i) < NREGS) begin
            rf_q[bus.wb_addr_i[AW-1:0]] <= bus.wb_data_i;
        end
    end

    logic [3:0]      alu_d, alu_q;
    logic [XLEN-1:0] op1_d, op1_q, op2_d, op2_q, tgt_d, tgt_q, rs2d_q;
    logic [4:0]      rd_q;
    logic            reg_wr_d, reg_wr_q, mem_en_d, mem_en_q, mem_wr_d, mem_wr_q;
    logic            br_d, br_q, ill_d, ill_q, taken;
    logic            use_rd, use_rs1, use_rs2;

    always_comb begin
        case (f3)
            3'b000:  taken = (rs1_val == rs2_val);
            3'b001:  taken = (rs1_val != rs2_val);
            3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  taken = (rs1_val <  rs2_val);
            default: taken = (rs1_val >= rs2_val);
        endcase
    end

    always_comb begin
        alu_d = ALU_ADD;  op1_d = rs1_val;  op2_d = imm_i;  tgt_d = bus.pc_i + imm_b;
        reg_wr_d = 1'b0;  mem_en_d = 1'b0;  mem_wr_d = 1'b0;  br_d = 1'b0;  ill_d = 1'b0;
        use_rd = 1'b0;    use_rs1 = 1'b0;   use_rs2 = 1'b0;
        case (opc)
            OP_R: begin
                {use_rd, use_rs1, use_rs2} = 3'b111;
                op2_d = rs2_val;  reg_wr_d = 1'b1;
                alu_d = alu_f3(f3, f7[5]);
                ill_d = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_IMM: begin
                {use_rd, use_rs1} = 2'b11;  reg_wr_d = 1'b1;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    op2_d = shamt;
                    alu_d = alu_f3(f3, f3 == 3'b101 && f7[5]);
                    ill_d = !(f7 == 7'h00 || (f3 == 3'b101 && f7 == 7'h20));
                end else begin
                    alu_d = alu_f3(f3, 1'b0);
                end
            end
            OP_LOAD: begin
                {use_rd, use_rs1} = 2'b11;  mem_en_d = 1'b1;  reg_wr_d = 1'b1;
                ill_d = (f3 == 3'b011 || f3[2:1] == 2'b11);
            end
            OP_STORE: begin
                {use_rs1, use_rs2} = 2'b11;  op2_d = imm_s;  mem_en_d = 1'b1;  mem_wr_d = 1'b1;
                ill_d = (f3[2] || f3 == 3'b011);
            end
            OP_LUI:   begin use_rd = 1'b1; op1_d = '0; op2_d = imm_u; alu_d = ALU_PASSB; reg_wr_d = 1'b1; end
            OP_AUIPC: begin use_rd = 1'b1; op1_d = bus.pc_i; op2_d = imm_u; reg_wr_d = 1'b1; end
            OP_JAL: begin
                use_rd = 1'b1;  op1_d = bus.pc_i;  op2_d = XLEN'(4);
                reg_wr_d = 1'b1;  br_d = 1'b1;  tgt_d = bus.pc_i + imm_j;
            end
            OP_JALR: begin
                {use_rd, use_rs1} = 2'b11;  op1_d = bus.pc_i;  op2_d = XLEN'(4);
                reg_wr_d = 1'b1;  br_d = 1'b1;  tgt_d = (rs1_val + imm_i) & ~XLEN'(1);
                ill_d = (f3 != 3'b000);
            end
            OP_BR: begin
                {use_rs1, use_rs2} = 2'b11;  op2_d = rs2_val;  br_d = taken;
                ill_d = (f3[2:1] == 2'b01);
            end
            default: ill_d = 1'b1;
        endcase
        // RV32E: any referenced register beyond the implemented file is illegal.
        if ((use_rd && 32'(rd_f) >= NREGS) || (use_rs1 && 32'(rs1_f) >= NREGS) ||
            (use_rs2 && 32'(rs2_f) >= NREGS))
            ill_d = 1'b1;
        if (ill_d) begin
            reg_wr_d = 1'b0;  mem_en_d = 1'b0;  mem_wr_d = 1'b0;  br_d = 1'b0;
        end
    end

    logic vld_q, vld_d, accept;
    assign bus.in_ready_o = !vld_q || bus.out_ready_i;
    assign accept = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;

    always_comb begin
        vld_d = vld_q;
        if (bus.flush_i)          vld_d = 1'b0;
        else if (accept)          vld_d = 1'b1;
        else if (bus.out_ready_i) vld_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vld_q <= 1'b0;  alu_q <= '0;  op1_q <= '0;  op2_q <= '0;  rs2d_q <= '0;  rd_q <= '0;
            reg_wr_q <= 1'b0;  mem_en_q <= 1'b0;  mem_wr_q <= 1'b0;  br_q <= 1'b0;
            tgt_q <= '0;  ill_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            if (accept) begin
                alu_q <= alu_d;  op1_q <= op1_d;  op2_q <= op2_d;  rs2d_q <= rs2_val;  rd_q <= rd_f;
                reg_wr_q <= reg_wr_d;  mem_en_q <= mem_en_d;  mem_wr_q <= mem_wr_d;  br_q <= br_d;
                tgt_q <= tgt_d;  ill_q <= ill_d;
            end
        end
    end

    assign bus.out_valid_o = vld_q;
    assign bus.alu_ctrl_o  = alu_q;
    assign bus.op1_o       = op1_q;
    assign bus.op2_o       = op2_q;
    assign bus.rs2_data_o  = rs2d_q;
    assign bus.rd_o        = rd_q;
    assign bus.reg_wr_o    = reg_wr_q;
    assign bus.mem_en_o    = mem_en_q;
    assign bus.mem_wr_o    = mem_wr_q;
    assign bus.branch_en_o = br_q;
    assign bus.pc_target_o = tgt_q;
    assign bus.illegal_o   = ill_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an RV32I instance carries most vectors, an RV32E
// instance covers the reduced register file.
module tb_decode_stage;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN)) ifa ();
    decode_stage_if #(.XLEN(XLEN)) ifb ();

    decode_stage #(.XLEN(XLEN), .NREGS(32)) u_i (.clk_i(clk), .reset_ni(rst_n), .bus(ifa));
    decode_stage #(.XLEN(XLEN), .NREGS(16)) u_e (.clk_i(clk), .reset_ni(rst_n), .bus(ifb));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        ifa.in_valid_i = 1'b1;  ifa.instruction_i = ins;  ifa.pc_i = pc;
        step();
        ifa.in_valid_i = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        ifa.wb_en_i = 1'b1;  ifa.wb_addr_i = a;  ifa.wb_data_i = d;
        step();
        ifa.wb_en_i = 1'b0;
    endtask

    localparam logic [31:0] ADDI_A0_A1_34 = 32'h02258513;
    localparam logic [31:0] SUB_A0_A1_A2  = 32'h40c58533;
    localparam logic [31:0] ADDI_A0_X0_34 = 32'h02200513;
    localparam logic [31:0] BEQ_X1_X2_16  = 32'h00208863;
    localparam logic [31:0] SW_A1_8_A2    = 32'h00b62423;
    localparam logic [31:0] LUI_A0        = 32'h12345537;

    initial begin
        ifa.in_valid_i = 1'b0;  ifa.instruction_i = '0;  ifa.pc_i = '0;  ifa.wb_en_i = 1'b0;
        ifa.wb_addr_i = '0;  ifa.wb_data_i = '0;  ifa.flush_i = 1'b0;  ifa.out_ready_i = 1'b1;
        ifb.in_valid_i = 1'b0;  ifb.instruction_i = '0;  ifb.pc_i = '0;  ifb.wb_en_i = 1'b0;
        ifb.wb_addr_i = '0;  ifb.wb_data_i = '0;  ifb.flush_i = 1'b0;  ifb.out_ready_i = 1'b1;

        repeat (2) step();
        chk("rst_valid", ifa.out_valid_o, 0);
        chk("rst_op1",   ifa.op1_o, 0);
        chk("rst_tgt",   ifa.pc_target_o, 0);
        chk("rst_alu",   ifa.alu_ctrl_o, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", ifa.in_ready_o, 1);

        // JAL forward and backward
        send(32'h0640056f, 32'd20);
        chk("jal_valid", ifa.out_valid_o, 1);
        chk("jal_br",    ifa.branch_en_o, 1);
        chk("jal_tgt",   ifa.pc_target_o, 120);
        chk("jal_op1",   ifa.op1_o, 20);
        chk("jal_op2",   ifa.op2_o, 4);
        chk("jal_rd",    ifa.rd_o, 10);
        chk("jal_regwr", ifa.reg_wr_o, 1);
        send(32'hf9dff56f, 32'd200);
        chk("jalneg_tgt", ifa.pc_target_o, 100);
        step();
        chk("drain_valid", ifa.out_valid_o, 0);

        // Register-file reads after writeback
        wb(5'd11, 32'd5);
        send(ADDI_A0_A1_34, 32'd0);
        chk("addi_op1", ifa.op1_o, 5);
        chk("addi_op2", ifa.op2_o, 34);
        chk("addi_alu", ifa.alu_ctrl_o, 0);
        wb(5'd12, 32'd7);
        send(SUB_A0_A1_A2, 32'd0);
        chk("sub_op1", ifa.op1_o, 5);
        chk("sub_op2", ifa.op2_o, 7);
        chk("sub_alu", ifa.alu_ctrl_o, 1);

        // Same-cycle bypass, and x0 stays zero
        ifa.wb_en_i = 1'b1;  ifa.wb_addr_i = 5'd11;  ifa.wb_data_i = 32'h55;
        send(ADDI_A0_A1_34, 32'd0);
        ifa.wb_en_i = 1'b0;
        chk("bypass_op1", ifa.op1_o, 32'h55);
        ifa.wb_en_i = 1'b1;  ifa.wb_addr_i = 5'd0;  ifa.wb_data_i = 32'hff;
        send(ADDI_A0_X0_34, 32'd0);
        ifa.wb_en_i = 1'b0;
        chk("x0_bypass_op1", ifa.op1_o, 0);
        send(ADDI_A0_X0_34, 32'd0);
        chk("x0_read_op1", ifa.op1_o, 0);

        // Branch resolved in decode
        wb(5'd1, 32'd3);
        wb(5'd2, 32'd3);
        send(BEQ_X1_X2_16, 32'd40);
        chk("beq_taken",  ifa.branch_en_o, 1);
        chk("beq_tgt",    ifa.pc_target_o, 56);
        chk("beq_regwr",  ifa.reg_wr_o, 0);
        wb(5'd2, 32'd4);
        send(BEQ_X1_X2_16, 32'd40);
        chk("beq_nottaken", ifa.branch_en_o, 0);

        // Store: x12=7 base, x11=0x55 data
        send(SW_A1_8_A2, 32'd0);
        chk("sw_op1",   ifa.op1_o, 7);
        chk("sw_op2",   ifa.op2_o, 8);
        chk("sw_mem",   {ifa.mem_en_o, ifa.mem_wr_o, ifa.reg_wr_o}, 3'b110);
        chk("sw_data",  ifa.rs2_data_o, 32'h55);

        // Backpressure: accept addi, then stall with sub offered
        send(ADDI_A0_A1_34, 32'd0);
        ifa.out_ready_i = 1'b0;
        ifa.in_valid_i = 1'b1;  ifa.instruction_i = SUB_A0_A1_A2;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_ready", ifa.in_ready_o, 0);
            chk("stall_valid", ifa.out_valid_o, 1);
            chk("stall_alu",   ifa.alu_ctrl_o, 0);
            chk("stall_op2",   ifa.op2_o, 34);
        end
        ifa.flush_i = 1'b1;
        step();
        chk("flush_valid", ifa.out_valid_o, 0);
        chk("flush_noacc", ifa.alu_ctrl_o, 0);
        ifa.flush_i = 1'b0;  ifa.out_ready_i = 1'b1;
        step();
        chk("postflush_valid", ifa.out_valid_o, 1);
        chk("postflush_alu",   ifa.alu_ctrl_o, 1);
        ifa.in_valid_i = 1'b0;  ifa.flush_i = 1'b1;
        step();
        chk("flush_rdy_valid", ifa.out_valid_o, 0);
        ifa.flush_i = 1'b0;

        // Back-to-back accepts
        ifa.in_valid_i = 1'b1;  ifa.instruction_i = ADDI_A0_A1_34;
        step();
        chk("b2b0_alu", ifa.alu_ctrl_o, 0);
        ifa.instruction_i = SUB_A0_A1_A2;
        step();
        chk("b2b1_alu", ifa.alu_ctrl_o, 1);
        chk("b2b1_valid", ifa.out_valid_o, 1);
        ifa.instruction_i = LUI_A0;
        step();
        chk("lui_alu", ifa.alu_ctrl_o, 10);
        chk("lui_op2", ifa.op2_o, 32'h12345000);
        ifa.in_valid_i = 1'b0;

        send(32'hffffffff, 32'd0);
        chk("ill_flag",  ifa.illegal_o, 1);
        chk("ill_ctrl",  {ifa.reg_wr_o, ifa.mem_en_o, ifa.mem_wr_o, ifa.branch_en_o}, 4'b0000);

        // Asynchronous reset with a bundle held
        send(ADDI_A0_A1_34, 32'd0);
        ifa.out_ready_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", ifa.out_valid_o, 0);
        chk("midrst_op1",   ifa.op1_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ifa.out_ready_i = 1'b1;
        send(ADDI_A0_A1_34, 32'd0);
        chk("midrst_rf", ifa.op1_o, 0);

        // RV32E instance
        ifb.in_valid_i = 1'b1;  ifb.instruction_i = 32'h00100a13;
        step();
        chk("e_x20_ill",   ifb.illegal_o, 1);
        chk("e_x20_regwr", ifb.reg_wr_o, 0);
        ifb.instruction_i = 32'h00100513;
        step();
        chk("e_a0_ill",   ifb.illegal_o, 0);
        chk("e_a0_regwr", ifb.reg_wr_o, 1);
        chk("e_a0_op2",   ifb.op2_o, 1);
        ifb.in_valid_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised RV32I/RV32E decode stage between fetch and execute. Holds the architectural register file and decodes one instruction per accepted transfer into ALU control, operands, memory and writeback controls, and resolved jump/branch target. Adds a valid/ready handshake on both sides, a flush input, a writeback bypass and illegal-instruction detection. Output is registered: one cycle of latency.

## Interface
- XLEN, 32, datapath and PC width (32 only for RV32; parameterised for the RV64 bring-up)
- NREGS, 32, architectural registers; 16 selects RV32E
- clk_i  in  1  clock, rising edge
- reset_ni  in  1  asynchronous, active-low reset
- in_valid_i  in  1  fetch presents instruction_i/pc_i
- in_ready_o  out  1  stage can accept this cycle
- instruction_i  in  32  raw instruction
- pc_i  in  XLEN  instruction address
- wb_en_i  in  1  register writeback strobe
- wb_addr_i  in  5  writeback register index
- wb_data_i  in  XLEN  writeback data
- flush_i  in  1  discard held and incoming instruction
- out_valid_o  out  1  decoded bundle valid
- out_ready_i  in  1  execute accepts bundle
- alu_ctrl_o  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10
- op1_o, op2_o  out  XLEN  ALU operands
- rs2_data_o  out  XLEN  store data
- rd_o  out  5  destination index
- reg_wr_o  out  1  rd is written
- mem_en_o, mem_wr_o  out  1 each  load/store access, store
- branch_en_o  out  1  redirect fetch to pc_target_o
- pc_target_o  out  XLEN  redirect address
- illegal_o  out  1  unsupported opcode/funct or register index >= NREGS

## Operation
- Handshake: in_ready_o = !out_valid_o || out_ready_i (combinational). Accept when in_valid_i && in_ready_o; bundle registered at that edge.
- out_valid_o: set on accept; cleared when out_ready_i without new accept; flush_i clears it next edge and blocks the same-cycle accept (flush wins).
- While out_valid_o && !out_ready_i, all outputs hold stable.
- Register file: NREGS x XLEN; x0 reads 0, writes to x0 ignored. Write at edge when wb_en_i. Bypass: read index equal to wb_addr_i with wb_en_i returns wb_data_i in the same cycle.
- Immediates sign-extended to XLEN: I, S, B, U, J formats per ISA.
- R-type: op1=rs1, op2=rs2, ALU per funct3/funct7, reg_wr=1.
- OP-IMM: op1=rs1, op2=immI (shamt for shifts), reg_wr=1.
- LOAD/STORE: op1=rs1, op2=immI/immS, ADD, mem_en=1, mem_wr=STORE, reg_wr=LOAD, rs2_data=rs2.
- LUI: op2=immU, PASSB. AUIPC: op1=pc, op2=immU, ADD.
- JAL: op1=pc, op2=4, ADD, reg_wr=1, branch_en=1, target=pc+immJ. JALR: same link, target=(rs1+immI)&~1.
- BRANCH: compare rs1/rs2 in decode (BEQ BNE BLT BGE BLTU BGEU); branch_en=taken; target=pc+immB; reg_wr=0.
- Illegal: illegal_o=1, reg_wr/mem_en/mem_wr/branch_en=0, other fields don't-care; still handshakes normally.

## Timing
- Reset (async assert): out_valid_o=0 and every registered output 0, all registers 0; in_ready_o=1 once reset_ni high.
- Latency: accept at edge N -> bundle valid after edge N, consumed at first edge with out_ready_i.
- Full throughput: back-to-back accepts with out_ready_i held high.
- Writeback at edge N visible to decode from edge N (bypass) onward.
- Reset mid-operation: held bundle dropped, no partial register write.
- Simultaneous flush_i and out_ready_i: out_valid_o=0 next edge.

## Test plan
- pc=20, 0x0640056f (JAL a0,100) -> branch_en=1, target=120, op1=20, op2=4, rd=10, reg_wr=1; pc=200, 0xf9dff56f (JAL a0,-100) -> target=100.
- wb x11=5, then 0x02258513 (addi a0,a1,34) -> op1=5, op2=34, ADD; wb x12=7, 0x40c58533 (sub) -> op1=5, op2=7, SUB.
- wb x11=0x55 in same cycle as decode of addi -> op1=0x55 (bypass); wb to x0=0xFF -> x0 reads 0.
- BEQ x1,x2,+16 at pc=40: x1=x2=3 -> branch_en=1, target=56; x2=4 -> branch_en=0.
- out_ready_i low 5 cycles with in_valid_i high -> in_ready_o=0, outputs stable; flush_i pulse -> out_valid_o=0 next edge, no accept that cycle.
- reset_ni low while out_valid_o=1 -> out_valid_o=0 immediately, registers 0; NREGS=16 with rd=x20 -> illegal_o=1, reg_wr=0.
